// File: rtl/pcie_ava_tx_cpl_engine.sv
// CplD generator for the 128-bit Avalon-ST TX port of the PCIe hard IP.
// One request (1-4 DW) becomes one 3DW-header completion, honouring ready latency 2.
module pcie_ava_tx_cpl_engine #(
  parameter int CPL_CNT_W = 16
) (
  input  logic                 pld_clk,
  input  logic                 srst,
  input  logic [15:0]          completer_id,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [15:0]          req_rid,
  input  logic [7:0]           req_tag,
  input  logic [6:0]           req_lower_addr,
  input  logic [2:0]           req_len,
  input  logic [127:0]         req_data,
  input  logic                 tx_st_ready0,
  output logic                 tx_st_valid0,
  output logic [127:0]         tx_st_data0,
  output logic                 tx_st_sop0,
  output logic                 tx_st_eop0,
  output logic                 tx_st_empty0,
  output logic                 tx_st_err0,
  output logic                 bad_req,
  output logic [CPL_CNT_W-1:0] cpl_count
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t         state, state_nxt;
  logic           rdy_d1, rdy_d2;
  logic           accept, len_ok;
  logic [15:0]    cid_q, rid_q;
  logic [7:0]     tag_q;
  logic [6:0]     la_q;
  logic [2:0]     len_q;
  logic [127:0]   data_q;

  // Request fields as they will stand next cycle: the beat register must be
  // loaded in the accept cycle, before the request registers themselves update.
  logic [15:0]    f_cid, f_rid;
  logic [7:0]     f_tag;
  logic [6:0]     f_la;
  logic [2:0]     f_len;
  logic [127:0]   f_data;
  logic [31:0]    h0, h1, h2;

  logic           valid_nxt, sop_nxt, eop_nxt, empty_nxt;
  logic [127:0]   beat_nxt;

  assign req_ready  = (state == IDLE) && !srst;
  assign accept     = req_valid && req_ready;
  assign len_ok     = (req_len != 3'd0) && (req_len <= 3'd4);
  assign tx_st_err0 = 1'b0;

  assign f_cid  = accept ? completer_id   : cid_q;
  assign f_rid  = accept ? req_rid        : rid_q;
  assign f_tag  = accept ? req_tag        : tag_q;
  assign f_la   = accept ? req_lower_addr : la_q;
  assign f_len  = accept ? req_len        : len_q;
  assign f_data = accept ? req_data       : data_q;

  assign h0 = {1'b0, 2'b10, 5'b01010, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0,
               2'b00, 2'b00, 7'b0, f_len};
  assign h1 = {f_cid, 3'b000, 1'b0, 7'b0, f_len, 2'b00};
  assign h2 = {f_rid, f_tag, 1'b0, f_la};

  function automatic logic [127:0] dw_keep(input logic [127:0] src, input logic [2:0] n);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (i < int'(n)) r[32*i +: 32] = src[32*i +: 32];
    return r;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge pld_clk) begin
    if (srst) begin
      state  <= IDLE;
      rdy_d1 <= 1'b0;
      rdy_d2 <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_d1 <= tx_st_ready0;
      rdy_d2 <= rdy_d1;
    end
  end

  // NOTE: request registers carry no reset; they are only read after a load.
  always_ff @(posedge pld_clk) begin
    if (accept) begin
      cid_q  <= completer_id;
      rid_q  <= req_rid;
      tag_q  <= req_tag;
      la_q   <= req_lower_addr;
      len_q  <= req_len;
      data_q <= req_data;
    end
  end

  // A beat is on the bus this cycle exactly when rdy_d2 is high outside IDLE.
  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && len_ok) state_nxt = HDR;
      HDR:     if (rdy_d2) state_nxt = (la_q[2] && len_q == 3'd1) ? IDLE : DATA;
      DATA:    if (rdy_d2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next-cycle beat: rdy_d1 now is rdy_d2 then, state_nxt is the state then.
  always_comb begin
    valid_nxt = 1'b0;
    sop_nxt   = 1'b0;
    eop_nxt   = 1'b0;
    empty_nxt = 1'b0;
    beat_nxt  = '0;
    if (rdy_d1) begin
      case (state_nxt)
        HDR: begin
          valid_nxt = 1'b1;
          sop_nxt   = 1'b1;
          eop_nxt   = f_la[2] && (f_len == 3'd1);
          beat_nxt  = {(f_la[2] ? f_data[31:0] : 32'h0), h2, h1, h0};
        end
        DATA: begin
          valid_nxt = 1'b1;
          eop_nxt   = 1'b1;
          if (f_la[2]) begin
            beat_nxt  = dw_keep({32'h0, f_data[127:32]}, f_len - 3'd1);
            empty_nxt = (f_len <= 3'd3);
          end else begin
            beat_nxt  = dw_keep(f_data, f_len);
            empty_nxt = (f_len <= 3'd2);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pld_clk) begin
    if (srst) begin
      tx_st_valid0 <= 1'b0;
      tx_st_sop0   <= 1'b0;
      tx_st_eop0   <= 1'b0;
      tx_st_empty0 <= 1'b0;
      tx_st_data0  <= '0;
      bad_req      <= 1'b0;
      cpl_count    <= '0;
    end else begin
      tx_st_valid0 <= valid_nxt;
      tx_st_sop0   <= sop_nxt;
      tx_st_eop0   <= eop_nxt;
      tx_st_empty0 <= empty_nxt;
      tx_st_data0  <= beat_nxt;
      if (accept && !len_ok) bad_req <= 1'b1;
      if (tx_st_valid0 && tx_st_eop0) cpl_count <= cpl_count + 1'b1;
    end
  end

endmodule

// File: doc/pcie_ava_tx_cpl_engine.md
# pcie_ava_tx_cpl_engine

Completion generator for the 128-bit Avalon-ST TX interface of the Stratix IV Gen2 x4 PCIe hard IP. It accepts single completion requests from the application (up to 4 DW of read data) and formats and transmits one 3DW CplD TLP per request on `tx_st_*0`. It honours the hard IP's two-cycle ready latency and Altera's 128-bit header/data alignment rules. It is the transmit-side counterpart to the application logic that consumes `rx_st_*0`.

## Interface
Parameters:
- `CPL_CNT_W`, 16: width of the sent-completion counter.

Ports:
- `pld_clk`  in  1  Avalon core clock, 125 MHz; the only clock.
- `srst`  in  1  synchronous, active-high reset.
- `completer_id`  in  16  bus/dev/func placed in header DW1[31:16]; sampled on request accept.
- `req_valid`  in  1  completion request valid.
- `req_ready`  out  1  block can accept a request.
- `req_rid`  in  16  requester ID.
- `req_tag`  in  8  request tag.
- `req_lower_addr`  in  7  lower address; bits [1:0] must be 0.
- `req_len`  in  3  payload length in DW; legal values 1–4.
- `req_data`  in  128  payload; DW i in bits [32i+31:32i].
- `tx_st_ready0`  in  1  hard IP ready.
- `tx_st_valid0`  out  1  beat valid.
- `tx_st_data0`  out  128  beat data.
- `tx_st_sop0`  out  1  start of packet.
- `tx_st_eop0`  out  1  end of packet.
- `tx_st_empty0`  out  1  upper 64 bits unused on the EOP beat.
- `tx_st_err0`  out  1  tied 0.
- `bad_req`  out  1  sticky: an illegal `req_len` was accepted.
- `cpl_count`  out  CPL_CNT_W  number of completions whose EOP has been sent; wraps.

## Operation
- States: IDLE, HDR, DATA.
- IDLE:
  - `req_ready` = 1 only in IDLE.
  - On `req_valid & req_ready`, all `req_*` and `completer_id` are registered.
  - If `req_len` is in 1..4, go to HDR. Otherwise set `bad_req`, emit nothing, and stay in IDLE.
- Header dwords (byte 0 in bits [31:24] of each DW):
  - H0 = {1'b0, Fmt 2'b10, Type 5'b01010, 1'b0, TC 3'b0, 4'b0, TD 0, EP 0, Attr 2'b0, 2'b0, Length 10'(len)}.
  - H1 = {completer_id, Status 3'b000, BCM 0, ByteCount 12'(len*4)}.
  - H2 = {req_rid, req_tag, 1'b0, req_lower_addr}.
- HDR beat, `sop`=1:
  - data = {X, H2, H1, H0}, with H0 in [31:0].
  - X = DW0 if `lower_addr[2]`=1 (unaligned), else 0.
  - Unaligned with len=1: `eop`=1, `empty`=0, go to IDLE.
  - All other cases: go to DATA.
- DATA beat, `eop`=1:
  - Aligned: data = DW0..DW(len-1) starting at [31:0]. `empty` = (len ≤ 2).
  - Unaligned: data = DW1..DW(len-1) starting at [31:0]. `empty` = (len-1 ≤ 2).
  - Unused DWs are driven 0. Go to IDLE.
- `cpl_count` increments on every EOP beat actually emitted.
- Width rule: ByteCount = {7'b0, len, 2'b00}.

## Timing
- Ready latency is 2. Let `rdy_d2` = `tx_st_ready0` delayed two cycles through a free-running pipeline that is cleared by `srst`.
- A beat may be presented (`tx_st_valid0`=1) in cycle N only if `rdy_d2`=1 in cycle N. The beat is consumed in that same cycle.
- A state advances only when its beat is presented. If `rdy_d2`=0, `valid`=0 and the state holds.
- All `tx_st_*0` outputs are registered.
- When `valid`=0: data=0, sop=eop=empty=0.
- Latency: request accepted in cycle A → HDR beat at the earliest in cycle A+1 (requires `tx_st_ready0` high in A-1) → DATA beat at the earliest in A+2 → `req_ready` high again in the cycle after the EOP beat.
- Maximum throughput: one 2-beat TLP every 3 cycles; one 1-beat TLP every 2 cycles.
- Ready dropping mid-packet: valid deasserts 2 cycles later; the packet resumes with the next DATA beat and is never restarted.
- Reset values: `req_ready`=0 during `srst` and 1 on the first cycle after it. `tx_st_valid0`=sop=eop=empty=err=0, data=0, `bad_req`=0, `cpl_count`=0, state=IDLE, ready pipeline=0.
- `srst` asserted mid-packet: the packet is abandoned. Outputs take their reset values in the next cycle and no EOP is sent.
- `cpl_count` wraps from all-ones to 0.

## Test plan
- Aligned len=1: rid=0x0100, tag=0x05, lower_addr=0x00, DW0=0xDEADBEEF, `completer_id`=0x0200, ready held high → HDR beat with H0=0x4A000001, H1=0x02000004, H2=0x01000500; DATA beat with [31:0]=0xDEADBEEF, `empty`=1; `cpl_count`=1.
- Unaligned len=1: lower_addr=0x04 → single beat with sop=eop=1, `empty`=0, [127:96]=DW0, H2[6:0]=0x04.
- Unaligned len=4 and aligned len=3: DATA beat holds DW1..DW3 (`empty`=0) and DW0..DW2 (`empty`=0) respectively; H1 ByteCount 0x010 and 0x00C.
- Ready toggling 1,0,0,1 mid-packet: valid stays 0 exactly in the cycles 2 after ready was low; beat order sop→eop is preserved; no duplicate or dropped beat.
- `req_len`=0 and 5: no TLP emitted, `bad_req`=1 and sticky, `req_ready` back high next cycle.
- `srst` asserted between HDR and DATA: next cycle valid=0, `cpl_count` unchanged/reset to 0, IDLE. A new request afterwards produces a correct full TLP.
